// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cdc_pkg
// Description : Shared constants for fast-to-slow single-bit crossings:
//               pulse stretcher FSM state encoding and the default
//               stretch/gap widths also used by synchronizer instantiations.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

    // Stretcher FSM state encoding
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HIGH   = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // Default level widths in fast_clk cycles. Each must be at least
    // 2*(fast/slow frequency ratio)+1 for the slow 2-FF synchronizer to
    // capture both edges of every stretched pulse.
    localparam int c_DEFAULT_STRETCH_CYCLES = 6;
    localparam int c_DEFAULT_GAP_CYCLES     = 6;
    localparam int c_DEFAULT_PEND_W         = 2;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/sat_updown_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_updown_cnt
// Description : Saturating up/down counter. Counts up on inc, down on dec,
//               holds when both or neither are asserted. sat_hit flags an
//               increment that was lost because the counter is already full.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               inc     - increment request
//               dec     - decrement request
//               count   - current count (registered)
//               sat_hit - combinational: inc lost to saturation this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sat_updown_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    logic [W-1:0] r_count;
    logic         w_is_max;
    logic         w_is_zero;
    logic         w_up;
    logic         w_down;

    assign w_is_max  = (r_count == c_MAX);
    assign w_is_zero = (r_count == '0);
    assign w_up      = inc & ~dec;
    assign w_down    = dec & ~inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_up && !w_is_max) begin
            r_count <= r_count + W'(1);
        end else if (w_down && !w_is_zero) begin
            r_count <= r_count - W'(1);
        end
    end

    assign count   = r_count;
    assign sat_hit = w_up & w_is_max;

endmodule : sat_updown_cnt
`default_nettype wire

// File: rtl/pulse_stretch_fast.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch_fast
// Description : Converts single-cycle event pulses into level pulses with a
//               guaranteed minimum high and low width, ahead of a fast-to-slow
//               2-FF synchronizer. Events arriving while a pulse is in flight
//               are queued in a saturating pending counter; a dropped event
//               sets a sticky overflow flag.
// Ports       : fast_clk     - fast domain clock
//               reset        - synchronous active-high reset
//               pulse_in     - event pulse, one event per high cycle
//               clr_overflow - clears sticky overflow (a same-cycle set wins)
//               stretch_out  - registered stretched level to the synchronizer
//               busy         - pulse in flight or events pending
//               pend_count   - queued events not yet emitted
//               overflow     - sticky: an event was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch_fast
    import cdc_pkg::*;
#(
    parameter int STRETCH_CYCLES = c_DEFAULT_STRETCH_CYCLES,
    parameter int GAP_CYCLES     = c_DEFAULT_GAP_CYCLES,
    parameter int PEND_W         = c_DEFAULT_PEND_W
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clr_overflow,
    output logic              stretch_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("pulse_stretch_fast: STRETCH_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pulse_stretch_fast: GAP_CYCLES must be >= 1");
    end
    if (PEND_W < 1) begin : g_bad_pend_w
        $error("pulse_stretch_fast: PEND_W must be >= 1");
    end

    // Width counter holds (cycles - 1) and counts down to zero; it is
    // reloaded on every state entry so it never wraps.
    localparam int c_MAX_CYCLES = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_HIGH_LOAD = c_CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [c_CNT_W-1:0]   r_width_cnt;
    logic [c_CNT_W-1:0]   w_width_next;
    logic                 r_stretch;
    logic                 r_overflow;
    logic                 w_start;
    logic                 w_consume;
    logic                 w_cnt_done;
    logic                 w_sat_hit;
    logic [PEND_W-1:0]    w_pend_count;

    // A pulse may start from a fresh event or from the pending queue.
    assign w_start    = pulse_in | (w_pend_count != '0);
    assign w_cnt_done = (r_width_cnt == '0);

    // ------------------------------------------------------------------
    // Next-state / width counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_width_next = r_width_cnt;
        w_consume    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_HIGH;
                    w_width_next = c_HIGH_LOAD;
                    w_consume    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_cnt_done) begin
                    w_state_next = ST_GAP;
                    w_width_next = c_GAP_LOAD;
                end else begin
                    w_width_next = r_width_cnt - c_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (w_cnt_done) begin
                    // Restart straight from the last gap cycle so back-to-back
                    // events run at a STRETCH+GAP period with no idle bubble.
                    if (w_start) begin
                        w_state_next = ST_HIGH;
                        w_width_next = c_HIGH_LOAD;
                        w_consume    = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_width_next = '0;
                    end
                end else begin
                    w_width_next = r_width_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_width_next = '0;
            end
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_width_cnt <= '0;
            r_stretch   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_width_cnt <= w_width_next;
            // Output flop mirrors the HIGH state so the synchronizer sees a
            // glitch-free registered level.
            r_stretch   <= (w_state_next == ST_HIGH);
            if (w_sat_hit) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-event counter: arrivals up, consumptions down. An arrival
    // consumed in the same cycle nets to no change.
    // ------------------------------------------------------------------
    sat_updown_cnt #(
        .W (PEND_W)
    ) u_pend_cnt (
        .clk     (fast_clk),
        .rst     (reset),
        .inc     (pulse_in),
        .dec     (w_consume),
        .count   (w_pend_count),
        .sat_hit (w_sat_hit)
    );

    assign stretch_out = r_stretch;
    assign busy        = (r_state != ST_IDLE) | (w_pend_count != '0);
    assign pend_count  = w_pend_count;
    assign overflow    = r_overflow;

endmodule : pulse_stretch_fast
`default_nettype wire

// File: tb/tb_pulse_stretch_fast.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretch_fast
// Description : Self-checking bench for pulse_stretch_fast. A timeline model
//               (next permitted start cycle, last start cycle, pending count)
//               predicts each cycle's outputs into a scoreboard queue; a
//               monitor compares the DUT against it on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch_fast;

    localparam int c_S    = 6;
    localparam int c_G    = 6;
    localparam int c_PW   = 2;
    localparam int c_PMAX = (1 << c_PW) - 1;

    logic            fast_clk = 1'b0;
    logic            reset = 1'b1;
    logic            pulse_in = 1'b0;
    logic            clr_overflow = 1'b0;
    logic            stretch_out;
    logic            busy;
    logic [c_PW-1:0] pend_count;
    logic            overflow;

    pulse_stretch_fast #(
        .STRETCH_CYCLES (c_S),
        .GAP_CYCLES     (c_G),
        .PEND_W         (c_PW)
    ) dut (
        .fast_clk     (fast_clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .clr_overflow (clr_overflow),
        .stretch_out  (stretch_out),
        .busy         (busy),
        .pend_count   (pend_count),
        .overflow     (overflow)
    );

    always #5 fast_clk = ~fast_clk;

    typedef struct {
        logic stretch;
        logic busy;
        int   pend;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   r_rises  = 0;
    logic r_prev_stretch = 1'b0;

    // Timeline model state
    int m_t       = 0;
    int m_pend    = 0;
    int m_free_at = 0;
    int m_last    = -1000;
    bit m_ovf     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the sampling edge
    // and queue the outputs expected for the following cycle.
    task automatic step(input bit rst, input bit pin, input bit clr);
        int   avail;
        bit   drop;
        exp_t e;
        reset        = rst;
        pulse_in     = pin;
        clr_overflow = clr;
        @(posedge fast_clk);
        if (rst) begin
            m_pend    = 0;
            m_ovf     = 1'b0;
            m_free_at = m_t + 1;
            m_last    = -1000;
        end else begin
            avail = m_pend + int'(pin);
            drop  = 1'b0;
            if (m_t >= m_free_at && avail > 0) begin
                // Emission occupies S high + G low cycles; next start edge
                // is the last low cycle.
                m_last    = m_t;
                m_free_at = m_t + c_S + c_G;
                m_pend    = avail - 1;
            end else if (avail > c_PMAX) begin
                m_pend = c_PMAX;
                drop   = 1'b1;
            end else begin
                m_pend = avail;
            end
            if (drop)     m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        e.stretch = ((m_t + 1) > m_last) && ((m_t + 1) <= m_last + c_S);
        e.busy    = ((m_t + 1) <= m_last + c_S + c_G) || (m_pend != 0);
        e.pend    = m_pend;
        e.ovf     = m_ovf;
        sb_q.push_back(e);
        m_t++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge fast_clk);
            if (stretch_out === 1'b1 && r_prev_stretch === 1'b0) r_rises++;
            r_prev_stretch = stretch_out;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stretch_out", 32'(stretch_out), 32'(e.stretch));
                chk("busy",        32'(busy),        32'(e.busy));
                chk("pend_count",  32'(pend_count),  32'(e.pend));
                chk("overflow",    32'(overflow),    32'(e.ovf));
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(3);

        // Single pulse
        step(1'b0, 1'b1, 1'b0);
        idle(20);

        // Two pulses two cycles apart
        step(1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        idle(30);

        // Pulse every cycle for 10 cycles: saturation, overflow, 4 emissions
        r_rises = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        idle(60);
        chk("burst_emissions", 32'(r_rises), 32'd4);

        // Mid-HIGH reset with two pending; pulse_in high during reset
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0);
        idle(15);

        // Overflow and clear in the same cycle, then clear alone
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(2);

        // Second pulse exactly on the last gap cycle
        r_rises = 0;
        step(1'b0, 1'b1, 1'b0);
        idle(c_S + c_G - 1);
        step(1'b0, 1'b1, 1'b0);
        idle(20);
        chk("last_gap_emissions", 32'(r_rises), 32'd2);

        // Randomized traffic with varying density
        for (int seg = 0; seg < 40; seg++) begin
            int dens;
            dens = $urandom_range(1, 100);
            for (int i = 0; i < 60; i++) begin
                bit r, p, c;
                r = ($urandom_range(0, 299) == 0);
                p = ($urandom_range(1, 100) <= dens);
                c = ($urandom_range(0, 19) == 0);
                step(r, p, c);
            end
        end
        idle(40);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge fast_clk);
        @(negedge fast_clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_stretch_fast
`default_nettype wire
